ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the decode stage. Holds the architectural PC and issues one instruction read per PC over a valid/ready memory read channel. Hands {instruction, pc} to decode with a valid/ready handshake, then waits for decode to resolve the next PC via pc_next/pc_write_enable. Non-speculative: at most one instruction is in flight between fetch and decode.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
XLEN, 32, width of PC, address and instruction data.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; asynchronous, active-low (0 = in reset).
pc_next  input  XLEN  next PC computed by decode.
pc_write_enable  input  1  decode commits pc_next this cycle.
ifu_receive_ready  input  1  decode can accept a new instruction.
ifu_send_valid  output  1  {instruction, pc} valid to decode.
instruction  output  32  fetched instruction word.
pc  output  XLEN  PC of the instruction word.
araddr  output  XLEN  memory read address.
arvalid  output  1  read address valid.
arready  input  1  memory accepts address.
rdata  input  32  read data.
rresp  input  2  read response; 2'b00 = OKAY.
rvalid  input  1  read data valid.
rready  output  1  fetch accepts read data.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, instruction=0, ifu_send_valid=0, arvalid=0, rready=0.
- States: IDLE, ADDR, DATA, SEND, WAIT_PC.
- IDLE -> ADDR unconditionally, one cycle after reset release.
- ADDR: arvalid=1, araddr=pc, both held stable until arready. On arvalid&&arready -> DATA.
- DATA: rready=1. On rvalid:
  - rresp==2'b00: instruction<=rdata.
  - rresp!=2'b00: instruction<=32'h0010_0073 (ebreak), halting simulation.
  - Then -> SEND.
  - rvalid in the same cycle as the address handshake is not accepted; data is sampled only in DATA.
- SEND: ifu_send_valid=1; instruction and pc held stable. On ifu_send_valid&&ifu_receive_ready -> WAIT_PC and ifu_send_valid falls next cycle.
- WAIT_PC: ifu_send_valid=0. On pc_write_enable: pc<={pc_next[XLEN-1:2],2'b00}, -> ADDR.
- pc_write_enable in the same cycle as the SEND handshake: PC loaded, go directly to ADDR (skip WAIT_PC).
- pc_write_enable in IDLE/ADDR/DATA, or in SEND without a handshake: ignored. Simulation-only assertion fires.
- pc changes only via reset or the commit above. araddr equals pc at all times.
- Minimum latency, fetch start to ifu_send_valid: 2 cycles with a zero-wait-state memory (ADDR 1 cycle, DATA 1 cycle).
- No outstanding reads beyond one. No new arvalid before the prior read's data is accepted.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: extra outputs fetch_cnt[31:0] and fetch_stall_cnt[31:0].
  - fetch_cnt increments on each accepted read data beat.
  - fetch_stall_cnt increments each cycle in ADDR with !arready, or in DATA with !rvalid.
  - Both counters wrap at 2^32, reset to 0 asynchronously.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ifu_pkg holds:
  - ifu_state_t enum (IDLE, ADDR, DATA, SEND, WAIT_PC).
  - EBREAK_INSN = 32'h0010_0073.
  - RESP_OKAY = 2'b00.
  - Default RESET_PC constant.
- Sub-module ifu_perf_cnt, instantiated only under IFU_PERF_CNT_EN: two wrapping 32-bit counters with increment enables.

Test Plan:
- Reset release, arready=1, rvalid one cycle after the address handshake, rdata=32'h0000_0093, rresp=0 -> araddr=32'h8000_0000; ifu_send_valid high 2 cycles after arvalid first rises with instruction=32'h0000_0093, pc=32'h8000_0000.
- Decode holds ifu_receive_ready=0 for 5 cycles, then 1 -> valid/instruction/pc stable across all 5 cycles, valid drops the cycle after the handshake, no arvalid until pc_write_enable.
- In WAIT_PC, pc_write_enable=1 with pc_next=32'h8000_0104 -> next cycle arvalid=1, araddr=32'h8000_0104. With pc_next=32'h8000_0106 -> araddr=32'h8000_0104.
- Read with rresp=2'b10, rdata=32'hDEAD_BEEF -> instruction=32'h0010_0073 presented to decode.
- rst pulled low while in DATA with rvalid pending -> same cycle: arvalid=0, rready=0, ifu_send_valid=0, pc=RESET_PC. After release, fetch restarts at 32'h8000_0000.
- IFU_PERF_CNT_EN defined, arready delayed 3 cycles on each of 2 fetches -> fetch_cnt=2, fetch_stall_cnt=6.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t      - fetch FSM state encoding
//   EBREAK_INSN      - word handed to decode when a read returns an error
//   RESP_OKAY        - read response code for a successful read
//   DEFAULT_RESET_PC - default architectural PC after reset
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    SEND,
    WAIT_PC
  } ifu_state_t;

  localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: single-beat memory read channel used by instruction fetch.
//   araddr/arvalid/arready - read address handshake
//   rdata/rresp/rvalid/rready - read data handshake
// Modports: master = fetch unit, slave = memory.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: two free-running wrapping 32-bit event counters.
//   clk, rst (async, active-low)
//   fetch_inc       - count an accepted read data beat
//   stall_inc       - count a cycle spent waiting on memory
//   fetch_cnt       - accepted read beats
//   fetch_stall_cnt - memory wait cycles
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] fetch_stall_cnt
);

  logic [1:0] inc;
  assign inc = {stall_inc, fetch_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc[gi]) begin
        cnt_reg <= cnt_reg + 32'd1;  // wraps naturally at 2^32
      end
    end
  end

  assign fetch_cnt       = g_cnt[0].cnt_reg;
  assign fetch_stall_cnt = g_cnt[1].cnt_reg;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: non-speculative instruction fetch stage feeding decode.
// Holds the PC, performs one read per PC on the memory channel, presents
// {instruction, pc} to decode, then waits for decode to commit the next PC.
// Ports:
//   clk, rst (async, active-low)
//   pc_next, pc_write_enable - next PC commit from decode
//   ifu_receive_ready        - decode can accept an instruction
//   ifu_send_valid, instruction, pc - instruction handed to decode
//   mem                      - memory read channel (ifu_fetch_if.master)
//   fetch_cnt, fetch_stall_cnt - only when IFU_PERF_CNT_EN is defined
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next,
  input  logic            pc_write_enable,
  input  logic            ifu_receive_ready,
  output logic            ifu_send_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  ifu_fetch_if.master     mem
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     fetch_stall_cnt
`endif
);

  ifu_state_t      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_reg_next;
  logic [31:0]     insn_reg, insn_next;
  logic            ar_hs, r_hs, send_hs;

  // Instruction fetch is word aligned; the low PC bits from decode are dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_next[1:0];

  assign ar_hs   = (state_reg == ADDR) && mem.arready;
  // Data is only sampled in DATA, so a beat coinciding with the address
  // handshake is never taken.
  assign r_hs    = (state_reg == DATA) && mem.rvalid;
  assign send_hs = (state_reg == SEND) && ifu_receive_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      insn_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_reg_next;
      insn_reg  <= insn_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_reg_next = pc_reg;
    insn_next   = insn_reg;
    unique case (state_reg)
      IDLE: state_next = ADDR;
      ADDR: begin
        if (ar_hs) state_next = DATA;
      end
      DATA: begin
        if (r_hs) begin
          // An error response turns into ebreak so the core traps cleanly.
          insn_next  = (mem.rresp == RESP_OKAY) ? mem.rdata : EBREAK_INSN;
          state_next = SEND;
        end
      end
      SEND: begin
        if (send_hs) begin
          if (pc_write_enable) begin
            // Decode resolved the next PC in the same cycle it took the
            // instruction: start the next fetch straight away.
            pc_reg_next = {pc_next[XLEN-1:2], 2'b00};
            state_next  = ADDR;
          end else begin
            state_next = WAIT_PC;
          end
        end
      end
      WAIT_PC: begin
        if (pc_write_enable) begin
          pc_reg_next = {pc_next[XLEN-1:2], 2'b00};
          state_next  = ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem.arvalid     = (state_reg == ADDR);
  assign mem.araddr      = pc_reg;
  assign mem.rready      = (state_reg == DATA);
  assign ifu_send_valid  = (state_reg == SEND);
  assign instruction     = insn_reg;
  assign pc              = pc_reg;

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk             (clk),
    .rst             (rst),
    .fetch_inc       (r_hs),
    .stall_inc       (((state_reg == ADDR) && !mem.arready) ||
                      ((state_reg == DATA) && !mem.rvalid)),
    .fetch_cnt       (fetch_cnt),
    .fetch_stall_cnt (fetch_stall_cnt)
  );
`endif

`ifndef SYNTHESIS
  // A PC commit is only meaningful while fetch is waiting for it.
  a_pc_write_legal: assert property (@(posedge clk) disable iff (!rst)
    pc_write_enable |-> ((state_reg == WAIT_PC) || send_hs));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a scoreboard on the
// decode-side handshake and a simple single-outstanding memory responder.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_next = '0;
  logic        pc_write_enable = 1'b0;
  logic        ifu_receive_ready = 1'b0;
  logic        ifu_send_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] fetch_stall_cnt;
`endif

  ifu_fetch_if #(.XLEN(32)) mif ();

  ifu_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_next           (pc_next),
    .pc_write_enable   (pc_write_enable),
    .ifu_receive_ready (ifu_receive_ready),
    .ifu_send_valid    (ifu_send_valid),
    .instruction       (instruction),
    .pc                (pc),
    .mem               (mif.master)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .fetch_stall_cnt   (fetch_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];   // {instruction, pc} expected at decode
  int          ar_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return {2'b00, 32'h0000_0093};
      32'h8000_0104: return {2'b00, 32'h0010_0113};
      32'h8000_0200: return {2'b10, 32'hDEAD_BEEF};
      32'h8000_0300: return {2'b00, 32'h0000_0013};
      default:       return {2'b00, 32'h0000_0000};
    endcase
  endfunction

  // Memory: arready after ar_delay wait cycles, data beat on the next cycle.
  initial begin
    int          ar_wait;
    logic        rd_pend;
    logic [31:0] rd_addr;
    logic [33:0] w;
    ar_wait = 0;
    rd_pend = 1'b0;
    rd_addr = '0;
    mif.arready = 1'b0;
    mif.rvalid  = 1'b0;
    mif.rdata   = '0;
    mif.rresp   = 2'b00;
    forever begin
      @(negedge clk);
      mif.arready = 1'b0;
      mif.rvalid  = 1'b0;
      if (!rst) begin
        ar_wait = 0;
        rd_pend = 1'b0;
      end else if (rd_pend) begin
        w = mem_word(rd_addr);
        mif.rvalid = 1'b1;
        mif.rdata  = w[31:0];
        mif.rresp  = w[33:32];
        rd_pend    = 1'b0;
      end else if (mif.arvalid) begin
        if (ar_wait >= ar_delay) begin
          mif.arready = 1'b1;
          ar_wait     = 0;
          rd_pend     = 1'b1;
          rd_addr     = mif.araddr;
        end else begin
          ar_wait++;
        end
      end
    end
  end

  // Scoreboard monitor: every decode handshake must match the oldest expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && ifu_send_valid && ifu_receive_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got insn %h pc %h, required no transfer", instruction, pc);
        end else begin
          e = exp_q.pop_front();
          $display("xfer t=%0t insn=%h pc=%h (exp insn=%h pc=%h)", $time, instruction, pc, e[63:32], e[31:0]);
          check("sb_insn", instruction, e[63:32]);
          check("sb_pc", pc, e[31:0]);
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    int k = 0;
    while (!ifu_send_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ifu_send_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: ifu_send_valid got 0 required 1 within 100 cycles", name);
    end
  endtask

  task automatic wait_arvalid(input string name);
    int k = 0;
    while (!mif.arvalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!mif.arvalid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: arvalid got 0 required 1 within 100 cycles", name);
    end
  endtask

  task automatic wait_rready(input string name);
    int k = 0;
    while (!mif.rready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!mif.rready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: rready got 0 required 1 within 100 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #2 rst = 1'b0;
    #1;
    check("rst_arvalid", mif.arvalid, 32'd0);
    check("rst_rready", mif.rready, 32'd0);
    check("rst_valid", ifu_send_valid, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_insn", instruction, 32'd0);

    // First fetch, zero-wait memory.
    exp_q.push_back({32'h0000_0093, RST_PC});
    @(negedge clk);
    rst = 1'b1;
    wait_arvalid("first_ar");
    check("first_araddr", mif.araddr, RST_PC);
    lat = 0;
    while (!ifu_send_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd2);

    // Decode stalls for 5 cycles: output must hold.
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", ifu_send_valid, 32'd1);
      check("hold_insn", instruction, 32'h0000_0093);
      check("hold_pc", pc, RST_PC);
      @(negedge clk);
    end
    ifu_receive_ready = 1'b1;
    @(negedge clk);
    ifu_receive_ready = 1'b0;
    check("valid_drop", ifu_send_valid, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("waitpc_no_ar", mif.arvalid, 32'd0);
      @(negedge clk);
    end

    // Commit from WAIT_PC.
    pc_write_enable = 1'b1;
    pc_next = 32'h8000_0104;
    exp_q.push_back({32'h0010_0113, 32'h8000_0104});
    @(negedge clk);
    pc_write_enable = 1'b0;
    check("commit_arvalid", mif.arvalid, 32'd1);
    check("commit_araddr", mif.araddr, 32'h8000_0104);

    // Commit coincident with the decode handshake, misaligned target.
    ifu_receive_ready = 1'b1;
    wait_valid("f2");
    pc_write_enable = 1'b1;
    pc_next = 32'h8000_0106;
    exp_q.push_back({32'h0010_0113, 32'h8000_0104});
    @(negedge clk);
    pc_write_enable = 1'b0;
    check("direct_arvalid", mif.arvalid, 32'd1);
    check("align_araddr", mif.araddr, 32'h8000_0104);

    // Error response becomes ebreak.
    wait_valid("f3");
    pc_write_enable = 1'b1;
    pc_next = 32'h8000_0200;
    exp_q.push_back({32'h0010_0073, 32'h8000_0200});
    @(negedge clk);
    pc_write_enable = 1'b0;
    check("err_araddr", mif.araddr, 32'h8000_0200);

    // Reset while the data beat is pending.
    wait_valid("f4");
    pc_write_enable = 1'b1;
    pc_next = 32'h8000_0300;
    exp_q.push_back({32'h0000_0013, 32'h8000_0300});
    @(negedge clk);
    pc_write_enable = 1'b0;
    wait_rready("f5_data");
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_arvalid", mif.arvalid, 32'd0);
    check("mid_rst_rready", mif.rready, 32'd0);
    check("mid_rst_valid", ifu_send_valid, 32'd0);
    check("mid_rst_pc", pc, RST_PC);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    ar_delay = 3;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back({32'h0000_0093, RST_PC});
    rst = 1'b1;
    wait_arvalid("restart_ar");
    check("restart_araddr", mif.araddr, RST_PC);
    wait_valid("f6");
    @(negedge clk);
    pc_write_enable = 1'b1;
    pc_next = 32'h8000_0104;
    exp_q.push_back({32'h0010_0113, 32'h8000_0104});
    @(negedge clk);
    pc_write_enable = 1'b0;
    wait_valid("f7");
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd2);
    check("fetch_stall_cnt", fetch_stall_cnt, 32'd6);
`endif
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
